// File: rtl/img_frame_rx.sv
// img_frame_rx: parses a framed RGB444 image arriving byte-by-byte from a UART.
// Frame layout: HDR0 HDR1, then W*H byte pairs (hi,lo) forming 12-bit pixels,
// then one checksum byte equal to the 8-bit sum of all pixel bytes.
// Byte interface: i_rx_done is a one-cycle "byte valid" strobe qualifying
// i_rx_data. There is no ready/backpressure; every strobed byte is consumed.
// Output strobes (o_pix_valid, o_check_valid, o_frame_done, o_err) are
// registered and exactly one clock wide.
module img_frame_rx #(
  parameter int          W           = 200,
  parameter int          H           = 150,
  parameter logic [7:0]  HDR0        = 8'hAA,
  parameter logic [7:0]  HDR1        = 8'h55,
  parameter int          TIMEOUT_CYC = 50_000_000
) (
  input  logic        i_clk_sys,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_done,
  input  logic        i_enable,
  output logic [11:0] o_pix,
  output logic [14:0] o_pix_addr,
  output logic        o_pix_valid,
  output logic        o_receiving,
  output logic [7:0]  o_check_code,
  output logic        o_check_valid,
  output logic        o_frame_done,
  output logic        o_err,
  output logic [3:0]  o_rcv_state
);

  localparam int ADDR_W = 15;
  localparam int CNT_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(W * H - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_HDR    = 4'd1,
    S_PIX_HI = 4'd2,
    S_PIX_LO = 4'd3,
    S_CHK    = 4'd4,
    S_ERR    = 4'd6
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_sum;
  logic [3:0]         r_hi_nib;
  logic [CNT_W-1:0]   r_idle_cnt;
  logic               w_timeout;

  assign w_timeout   = (r_idle_cnt == TO_LAST);
  assign o_receiving = (r_state == S_PIX_HI) || (r_state == S_PIX_LO) || (r_state == S_CHK);
  assign o_rcv_state = r_state;

  // Idle-gap counter: restarts on every byte, parked at zero when no frame is open.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idle_cnt <= '0;
    end else if (i_rx_done || (r_state == S_IDLE) || (r_state == S_ERR)) begin
      r_idle_cnt <= '0;
    end else if (!w_timeout) begin
      r_idle_cnt <= r_idle_cnt + CNT_W'(1);
    end
  end

  // Frame FSM with registered pixel/checksum outputs and single-cycle strobes.
  // Priority: enable drop, then a received byte, then timeout.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_sum         <= '0;
      r_hi_nib      <= '0;
      o_pix         <= '0;
      o_pix_addr    <= '0;
      o_pix_valid   <= 1'b0;
      o_check_code  <= '0;
      o_check_valid <= 1'b0;
      o_frame_done  <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_pix_valid   <= 1'b0;
      o_check_valid <= 1'b0;
      o_frame_done  <= 1'b0;
      o_err         <= 1'b0;
      if (!i_enable && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_enable && i_rx_done && (i_rx_data == HDR0)) begin
              r_state <= S_HDR;
            end
          end
          S_HDR: begin
            if (i_rx_done) begin
              if (i_rx_data == HDR1) begin
                r_addr  <= '0;
                r_sum   <= '0;
                r_state <= S_PIX_HI;
              end else if (i_rx_data != HDR0) begin
                r_state <= S_IDLE;
              end
            end else if (w_timeout) begin
              o_err   <= 1'b1;
              r_state <= S_ERR;
            end
          end
          S_PIX_HI: begin
            if (i_rx_done) begin
              r_hi_nib <= i_rx_data[3:0];
              r_sum    <= r_sum + i_rx_data;
              r_state  <= S_PIX_LO;
            end else if (w_timeout) begin
              o_err   <= 1'b1;
              r_state <= S_ERR;
            end
          end
          S_PIX_LO: begin
            if (i_rx_done) begin
              r_sum       <= r_sum + i_rx_data;
              o_pix       <= {r_hi_nib, i_rx_data};
              o_pix_addr  <= r_addr;
              o_pix_valid <= 1'b1;
              if (r_addr == LAST_ADDR) begin
                r_state <= S_CHK;
              end else begin
                r_addr  <= r_addr + ADDR_W'(1);
                r_state <= S_PIX_HI;
              end
            end else if (w_timeout) begin
              o_err   <= 1'b1;
              r_state <= S_ERR;
            end
          end
          S_CHK: begin
            if (i_rx_done) begin
              o_check_code  <= r_sum;
              o_check_valid <= 1'b1;
              if (i_rx_data == r_sum) begin
                o_frame_done <= 1'b1;
              end else begin
                o_err <= 1'b1;
              end
              r_state <= S_IDLE;
            end else if (w_timeout) begin
              o_err   <= 1'b1;
              r_state <= S_ERR;
            end
          end
          S_ERR: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_img_frame_rx.sv
// Testbench for img_frame_rx with a small 4x2 image and a 100-cycle timeout.
module tb_img_frame_rx;

  localparam int         TW   = 4;
  localparam int         TH   = 2;
  localparam int         NPIX = TW * TH;
  localparam int         TO   = 100;
  localparam logic [7:0] H0   = 8'hAA;
  localparam logic [7:0] H1   = 8'h55;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst_n;
  logic [7:0]  i_rx_data;
  logic        i_rx_done;
  logic        i_enable;
  logic [11:0] o_pix;
  logic [14:0] o_pix_addr;
  logic        o_pix_valid;
  logic        o_receiving;
  logic [7:0]  o_check_code;
  logic        o_check_valid;
  logic        o_frame_done;
  logic        o_err;
  logic [3:0]  o_rcv_state;

  img_frame_rx #(.W(TW), .H(TH), .HDR0(H0), .HDR1(H1), .TIMEOUT_CYC(TO)) dut (
    .i_clk_sys    (clk),
    .i_rst_n      (i_rst_n),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .i_enable     (i_enable),
    .o_pix        (o_pix),
    .o_pix_addr   (o_pix_addr),
    .o_pix_valid  (o_pix_valid),
    .o_receiving  (o_receiving),
    .o_check_code (o_check_code),
    .o_check_valid(o_check_valid),
    .o_frame_done (o_frame_done),
    .o_err        (o_err),
    .o_rcv_state  (o_rcv_state)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  logic [26:0] exp_q[$];
  logic [26:0] obs_pix_q[$];
  logic [7:0]  obs_code_q[$];
  int          n_done = 0;
  int          n_err  = 0;
  int          n_bad  = 0;
  logic        prev_done = 1'b0;
  logic        prev_err  = 1'b0;
  logic        prev_cv   = 1'b0;

  logic [7:0]  body[2*NPIX];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Output monitor, sampled 1ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (o_pix_valid) obs_pix_q.push_back({o_pix_addr, o_pix});
    if (o_check_valid) obs_code_q.push_back(o_check_code);
    if (o_frame_done) n_done++;
    if (o_err) n_err++;
    if (o_pix_valid && (o_check_valid || o_frame_done || o_err)) n_bad++;
    if (o_frame_done && o_err) n_bad++;
    if ((o_frame_done && prev_done) || (o_err && prev_err) || (o_check_valid && prev_cv)) n_bad++;
    prev_done = o_frame_done;
    prev_err  = o_err;
    prev_cv   = o_check_valid;
  end

  task automatic clear_obs();
    obs_pix_q.delete();
    obs_code_q.delete();
    n_done = 0;
    n_err  = 0;
  endtask

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  // Reference model: pixel k is {low nibble of byte 2k, byte 2k+1} at address k;
  // checksum is the mod-256 sum of all pixel bytes.
  function automatic logic [7:0] body_sum();
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 2 * NPIX; i++) s = s + body[i];
    return s;
  endfunction

  task automatic new_body();
    body[0] = 8'h0F; body[1] = 8'hFF; body[2] = 8'h01; body[3] = 8'h23;
    for (int i = 4; i < 2 * NPIX; i++) body[i] = 8'($urandom);
  endtask

  task automatic load_expected();
    exp_q.delete();
    for (int k = 0; k < NPIX; k++) exp_q.push_back({15'(k), body[2*k][3:0], body[2*k+1]});
  endtask

  task automatic run_frame(input bit fresh, input bit bad);
    logic [7:0] s;
    logic [7:0] ck;
    if (fresh) new_body();
    s  = body_sum();
    ck = bad ? (s ^ 8'h01) : s;
    load_expected();
    clear_obs();
    send_byte(H0);
    send_byte(H1);
    chk("hdr_state", o_rcv_state, 32'd2);
    chk("hdr_receiving", o_receiving, 32'd1);
    for (int i = 0; i < 2 * NPIX; i++) send_byte(body[i]);
    chk("chk_state", o_rcv_state, 32'd4);
    send_byte(ck);
    repeat (3) @(negedge clk);
    chk("pix_count", obs_pix_q.size(), NPIX);
    while ((exp_q.size() > 0) && (obs_pix_q.size() > 0))
      chk("pix_addr_data", obs_pix_q.pop_front(), exp_q.pop_front());
    chk("check_count", obs_code_q.size(), 32'd1);
    if (obs_code_q.size() > 0) chk("check_code", obs_code_q.pop_front(), s);
    chk("frame_done", n_done, bad ? 32'd0 : 32'd1);
    chk("frame_err", n_err, bad ? 32'd1 : 32'd0);
    chk("end_state", o_rcv_state, 32'd0);
    chk("end_receiving", o_receiving, 32'd0);
  endtask

  // Safety net in case the design never responds.
  initial begin
    #500_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int to_k;
    i_rst_n   = 1'b0;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    i_enable  = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_pix", o_pix, 32'd0);
    chk("rst_addr", o_pix_addr, 32'd0);
    chk("rst_state", o_rcv_state, 32'd0);
    chk("rst_strobes", {o_pix_valid, o_check_valid, o_frame_done, o_err, o_receiving}, 32'd0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good frame, then the same frame with a corrupted checksum
    run_frame(1'b1, 1'b0);
    run_frame(1'b0, 1'b1);
    run_frame(1'b1, 1'b0);

    // Header resync: stray byte and repeated HDR0 before a frame
    send_byte(8'h12);
    chk("resync_idle", o_rcv_state, 32'd0);
    send_byte(H0);
    chk("resync_hdr", o_rcv_state, 32'd1);
    run_frame(1'b1, 1'b0);

    // Broken header returns to idle silently
    clear_obs();
    send_byte(H0);
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    chk("badhdr_state", o_rcv_state, 32'd0);
    chk("badhdr_pix", obs_pix_q.size(), 32'd0);
    chk("badhdr_err", n_err, 32'd0);

    // Timeout after three pixel bytes
    new_body();
    clear_obs();
    send_byte(H0);
    send_byte(H1);
    send_byte(body[0]);
    send_byte(body[1]);
    send_byte(body[2]);
    chk("to_pre_state", o_rcv_state, 32'd3);
    to_k = 0;
    for (int k = 1; k <= 2 * TO; k++) begin
      @(posedge clk);
      #1;
      if (o_err) begin
        to_k = k;
        break;
      end
    end
    chk("to_latency", to_k, TO);
    chk("to_err_state", o_rcv_state, 32'd6);
    @(posedge clk);
    #1;
    chk("to_after_state", o_rcv_state, 32'd0);
    chk("to_after_err", o_err, 32'd0);
    repeat (2) @(negedge clk);
    chk("to_err_count", n_err, 32'd1);
    chk("to_pix_count", obs_pix_q.size(), 32'd1);
    run_frame(1'b1, 1'b0);

    // Abort: enable drops in the same cycle as a low pixel byte
    new_body();
    load_expected();
    clear_obs();
    send_byte(H0);
    send_byte(H1);
    for (int i = 0; i < 5; i++) send_byte(body[i]);
    @(negedge clk);
    i_rx_data = body[5];
    i_rx_done = 1'b1;
    i_enable  = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_receiving", o_receiving, 32'd0);
    chk("abort_state", o_rcv_state, 32'd0);
    @(negedge clk);
    i_rx_done = 1'b0;
    for (int i = 6; i < 2 * NPIX; i++) send_byte(body[i]);
    repeat (TO + 20) @(negedge clk);
    chk("abort_pix_count", obs_pix_q.size(), 32'd2);
    while ((obs_pix_q.size() > 0) && (exp_q.size() > 0))
      chk("abort_pix", obs_pix_q.pop_front(), exp_q.pop_front());
    chk("abort_err", n_err, 32'd0);
    chk("abort_done", n_done, 32'd0);
    i_enable = 1'b1;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a frame
    new_body();
    clear_obs();
    send_byte(H0);
    send_byte(H1);
    send_byte(body[0]);
    send_byte(body[1]);
    send_byte(body[2]);
    chk("mid_state", o_rcv_state, 32'd3);
    chk("mid_pix", o_pix, {body[0][3:0], body[1]});
    @(negedge clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_pix", o_pix, 32'd0);
    chk("arst_addr", o_pix_addr, 32'd0);
    chk("arst_state", o_rcv_state, 32'd0);
    chk("arst_code", o_check_code, 32'd0);
    chk("arst_strobes", {o_pix_valid, o_check_valid, o_frame_done, o_err, o_receiving}, 32'd0);
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    chk("arst_release_state", o_rcv_state, 32'd0);
    run_frame(1'b1, 1'b0);

    chk("strobe_rules", n_bad, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
